// File: rtl/gcd_ctrl.sv
// Valid/ready front-end for the 8-bit binary GCD core: loads operands, waits for done, returns result.
// Zero operands bypass the core. Define GCD_CTRL_WATCHDOG_EN to add the WAIT-state watchdog.
module gcd_ctrl #(
  parameter int TIMEOUT = 100
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_u,
  input  logic [7:0] in_v,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_res,
  output logic       out_err,
  output logic       core_ld,
  output logic [7:0] core_u,
  output logic [7:0] core_v,
  input  logic [7:0] core_res,
  input  logic       core_done
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUT} state_t;

  state_t     state;
  logic [7:0] u_q, v_q;

  assign core_u = u_q;
  assign core_v = v_q;

`ifdef GCD_CTRL_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
  logic       err_q;
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      core_ld   <= 1'b0;
      out_valid <= 1'b0;
      u_q       <= 8'd0;
      v_q       <= 8'd0;
      out_res   <= 8'd0;
`ifdef GCD_CTRL_WATCHDOG_EN
      wait_cnt  <= 8'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          u_q      <= in_u;
          v_q      <= in_v;
          in_ready <= 1'b0;
          // The core never reaches u==v with a zero operand, so answer directly.
          if (in_u == 8'd0 || in_v == 8'd0) begin
            out_res   <= in_u | in_v;
            out_valid <= 1'b1;
`ifdef GCD_CTRL_WATCHDOG_EN
            err_q     <= 1'b0;
`endif
            state     <= OUT;
          end else begin
            core_ld <= 1'b1;
            state   <= LOAD;
          end
        end
        // core_done is stale here (core still holds the previous operands).
        LOAD: begin
          core_ld  <= 1'b0;
`ifdef GCD_CTRL_WATCHDOG_EN
          wait_cnt <= 8'd0;
`endif
          state    <= WAIT;
        end
        WAIT: begin
`ifdef GCD_CTRL_WATCHDOG_EN
          wait_cnt <= wait_cnt + 8'd1;
`endif
          if (core_done) begin
            out_res   <= core_res;
            out_valid <= 1'b1;
`ifdef GCD_CTRL_WATCHDOG_EN
            err_q     <= 1'b0;
`endif
            state     <= OUT;
          end
`ifdef GCD_CTRL_WATCHDOG_EN
          else if (wait_cnt == WD_LAST) begin
            out_res   <= 8'd0;
            err_q     <= 1'b1;
            out_valid <= 1'b1;
            state     <= OUT;
          end
`endif
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Directed bench for gcd_ctrl with a latency-programmable stub core.
module tb_gcd_ctrl;

  logic       clk = 1'b0;
  logic       resetb;
  logic       in_valid, in_ready, out_valid, out_ready, out_err;
  logic       core_ld, core_done;
  logic [7:0] in_u, in_v, out_res, core_u, core_v, core_res;

  int total = 0, passed = 0;
  int lat = 1, c_cnt = 0, cyc, lds;
  bit force0 = 1'b0, stable;

  always #5 clk = ~clk;

  gcd_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .resetb(resetb),
    .in_valid(in_valid), .in_ready(in_ready), .in_u(in_u), .in_v(in_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_err(out_err),
    .core_ld(core_ld), .core_u(core_u), .core_v(core_v),
    .core_res(core_res), .core_done(core_done)
  );

  function automatic logic [7:0] gcd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  // Stub core: done rises in WAIT cycle 'lat'; stays high (stale) until the next load.
  always @(posedge clk) begin
    if (core_ld) begin
      c_cnt    <= 1;
      core_res <= gcd(core_u, core_v);
    end else if (c_cnt != 0 && c_cnt < lat) c_cnt <= c_cnt + 1;
  end
  assign core_done = !force0 && c_cnt != 0 && c_cnt >= lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Accept an operand pair, then count cycles (from acceptance) until out_valid.
  task automatic send(input string tag, input logic [7:0] u, input logic [7:0] v);
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(in_ready), 1);
    in_valid = 1'b1; in_u = u; in_v = v;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1; lds = 0;
    while (!out_valid && cyc < 300) begin
      if (core_ld) lds++;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
  endtask

  task automatic recv(input string tag);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, 32'(out_valid), 0);
    chk({tag, " in_ready back"}, 32'(in_ready), 1);
  endtask

  initial begin
    resetb = 1'b0; in_valid = 1'b0; in_u = 8'd0; in_v = 8'd0; out_ready = 1'b0;
    #12;
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst core_ld", 32'(core_ld), 0);
    chk("rst core_uv", {16'd0, core_u, core_v}, 0);
    chk("rst out_res", 32'(out_res), 0);
    chk("rst out_err", 32'(out_err), 0);
    @(negedge clk); resetb = 1'b1;

    // (12,18): one load, 5 WAIT cycles -> out_valid at acceptance+7
    lat = 5;
    send("12_18", 8'd12, 8'd18);
    chk("12_18 core_u", 32'(core_u), 12);
    chk("12_18 core_v", 32'(core_v), 18);
    chk("12_18 ld pulses", lds, 1);
    chk("12_18 latency", cyc, 7);
    chk("12_18 res", 32'(out_res), 6);
    chk("12_18 err", 32'(out_err), 0);
    recv("12_18");

    // (7,7): stale done/res (6) present during LOAD must be ignored
    lat = 1;
    send("7_7", 8'd7, 8'd7);
    chk("7_7 latency", cyc, 3);
    chk("7_7 res", 32'(out_res), 7);
    recv("7_7");

    send("0_45", 8'd0, 8'd45);
    chk("0_45 ld pulses", lds, 0);
    chk("0_45 latency", cyc, 1);
    chk("0_45 res", 32'(out_res), 45);
    recv("0_45");

    send("0_0", 8'd0, 8'd0);
    chk("0_0 ld pulses", lds, 0);
    chk("0_0 latency", cyc, 1);
    chk("0_0 res", 32'(out_res), 0);
    recv("0_0");

    // Backpressure: result held 10 cycles
    lat = 3;
    send("48_36", 8'd48, 8'd36);
    chk("48_36 latency", cyc, 5);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(out_valid === 1'b1 && out_res === 8'd12 && in_ready === 1'b0)) stable = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    chk("48_36 held stable", 32'(stable), 1);
    chk("48_36 res", 32'(out_res), 12);
    recv("48_36");

`ifdef GCD_CTRL_WATCHDOG_EN
    // Watchdog, TIMEOUT=8: out_valid 9 cycles after LOAD (acceptance+10)
    force0 = 1'b1;
    send("wdog", 8'd20, 8'd30);
    chk("wdog latency", cyc, 10);
    chk("wdog err", 32'(out_err), 1);
    chk("wdog res", 32'(out_res), 0);
    recv("wdog");
    force0 = 1'b0;
`endif

    // Reset in the middle of WAIT
    lat = 50;
    @(negedge clk);
    in_valid = 1'b1; in_u = 8'd100; in_v = 8'd75;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("midrst busy", 32'(in_ready), 0);
    resetb = 1'b0;
    #1;
    chk("midrst in_ready", 32'(in_ready), 1);
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst core_ld", 32'(core_ld), 0);
    chk("midrst core_uv", {16'd0, core_u, core_v}, 0);
    chk("midrst out_res/err", {23'd0, out_err, out_res}, 0);
    @(negedge clk); resetb = 1'b1;

    lat = 2;
    send("9_6", 8'd9, 8'd6);
    chk("9_6 latency", cyc, 4);
    chk("9_6 res", 32'(out_res), 3);
    chk("9_6 err", 32'(out_err), 0);
    recv("9_6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gcd_ctrl.md
# gcd_ctrl

Handshake front-end for the 8-bit binary GCD core. It accepts operand pairs on a valid/ready input channel and drives the core's load port. It waits for the core's `done`, then presents the result on a valid/ready output channel. It bypasses the core for zero operands, which the core cannot terminate on, and optionally guards the core with a watchdog.

## Interface
Parameters:
- `TIMEOUT`, default 100: maximum number of WAIT cycles before the watchdog aborts the operation. Legal range 2..255.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock; all state updates on the rising edge.
  - `resetb`  in  1  asynchronous, active-low reset.
- Input channel:
  - `in_valid`  in  1  operand pair valid.
  - `in_ready`  out  1  controller can accept an operand pair.
  - `in_u`  in  8  operand u.
  - `in_v`  in  8  operand v.
- Output channel:
  - `out_valid`  out  1  result valid.
  - `out_ready`  in  1  downstream accepts the result.
  - `out_res`  out  8  gcd result.
  - `out_err`  out  1  operation aborted by the watchdog; `out_res` is 0.
- Core-facing:
  - `core_ld`  out  1  load strobe to the core.
  - `core_u`  out  8  operand u to the core.
  - `core_v`  out  8  operand v to the core.
  - `core_res`  in  8  core result.
  - `core_done`  in  1  core done (combinational u_reg==v_reg inside the core).

## Operation
- FSM states and outputs:
  - IDLE: `in_ready`=1.
  - LOAD: `core_ld`=1.
  - WAIT: the core is computing.
  - OUT: `out_valid`=1.
  - All these signals are 0 in every other state.
- Operand registers `u_q` and `v_q` capture `in_u`/`in_v` on acceptance (`in_valid & in_ready`). `core_u`=`u_q` and `core_v`=`v_q` at all times.
- IDLE, on acceptance:
  - If `in_u`==0 or `in_v`==0: `out_res` ← `in_u | in_v`, `out_err` ← 0, go to OUT. The core is not loaded.
  - Else: go to LOAD.
- LOAD: lasts exactly one cycle, then WAIT. `core_done` is ignored in LOAD because it reflects stale core state.
- WAIT: `wait_cnt` clears to 0 on entry and increments each WAIT cycle.
  - If `core_done`=1: `out_res` ← `core_res`, `out_err` ← 0, go to OUT.
  - Else, if `wait_cnt`==TIMEOUT-1 (watchdog enabled only): `out_res` ← 0, `out_err` ← 1, go to OUT.
- OUT: `out_res` and `out_err` are held stable while `out_valid`=1 and `out_ready`=0. When `out_ready`=1, go to IDLE.
- No new input is accepted until the current result is consumed. Throughput is one operation in flight.
- Widths: all data is 8-bit unsigned. `wait_cnt` is 8-bit and never wraps, because TIMEOUT ≤ 255.

## Timing
- Reset values: state=IDLE, `u_q`=`v_q`=0, `out_res`=0, `out_err`=0, `wait_cnt`=0. Resulting outputs: `in_ready`=1, `out_valid`=0, `core_ld`=0, `core_u`=`core_v`=0.
- Non-zero path, with acceptance at cycle t:
  - `core_ld`=1 in cycle t+1.
  - The core holds the operands from cycle t+2, which is the first WAIT cycle.
  - If `core_done` is first high in WAIT cycle k, `out_valid` rises in the following cycle.
- Zero path: acceptance at cycle t gives `out_valid`=1 in cycle t+1.
- Watchdog path: `out_valid` rises exactly TIMEOUT+1 cycles after the LOAD cycle.
- Simultaneous events:
  - `core_done`=1 in the same cycle as `wait_cnt`==TIMEOUT-1: done wins and `out_err`=0.
  - `out_ready` held high: OUT lasts one cycle. `in_ready` is 1 in the next cycle; there is no same-cycle turnaround.
- Reset asserted mid-operation: immediate return to the reset values. Any partial result is dropped and `core_ld` drops to 0 asynchronously.

## Configuration
- `GCD_CTRL_WATCHDOG_EN` defined: `wait_cnt` and the timeout path are present, as described above.
- `GCD_CTRL_WATCHDOG_EN` undefined:
  - WAIT exits only on `core_done`.
  - `out_err` is tied to 0.
  - `wait_cnt` is not implemented.
  - `TIMEOUT` is ignored.

## Test plan
- (12,18): `core_ld` pulses once, there are 5 WAIT cycles, then `out_res`=6 and `out_err`=0.
- (7,7): `core_done` is high in the first WAIT cycle; `out_valid` follows one cycle later with `out_res`=7.
- (0,45) → `out_res`=45. (0,0) → `out_res`=0. In both cases `core_ld` never asserts and `out_valid` is high one cycle after acceptance.
- Backpressure: hold `out_ready`=0 for 10 cycles after (48,36). Required: `out_res`=12 stays stable, `in_ready`=0 throughout, and IDLE resumes one cycle after `out_ready`=1.
- Watchdog (`GCD_CTRL_WATCHDOG_EN`, TIMEOUT=8, `core_done` forced to 0 by a stub core): `out_err`=1 and `out_res`=0, with `out_valid` 9 cycles after LOAD.
- Reset mid-WAIT during (100,75): all outputs return to their reset values. A following (9,6) then completes with `out_res`=3.
